barrier_ctrl: RTL and testbench

- Command-driven client of the single-port barrier SRAM (8-bit data, 16-bit address, 1-cycle registered read). It drives the SRAM's port; no other block drives it.
- Game logic issues probes, single-cell writes and whole-map fills as (x,y) commands.
- The block converts coordinates to SRAM addresses, sequences the SRAM port, bounds-checks, and returns collision results to the snake collision/update logic.

---
 rtl/barrier_pkg.sv | 23 ++
 rtl/barrier_addr.sv | 24 ++
 rtl/barrier_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_barrier_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/barrier_pkg.sv
// Shared types for the barrier SRAM controller: command op codes, controller
// states and the default map dimensions.
package barrier_pkg;

  typedef enum logic [1:0] {
    OP_PROBE = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    FILL
  } state_e;

  localparam int DEF_MAP_W = 256;
  localparam int DEF_MAP_H = 256;

endpackage

// File: rtl/barrier_addr.sv
// Combinational (x,y) -> linear SRAM address with out-of-bounds flag.
// Also used by the renderer's coordinate path.
module barrier_addr
  import barrier_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 8,
  parameter int MAP_W      = DEF_MAP_W,
  parameter int MAP_H      = DEF_MAP_H
) (
  input  logic [X_WIDTH-1:0]    x_i,
  input  logic [Y_WIDTH-1:0]    y_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  oob_o
);

  // The address is only meaningful when oob_o is low.
  always_comb begin
    addr_o = ADDR_WIDTH'(y_i) * ADDR_WIDTH'(MAP_W) + ADDR_WIDTH'(x_i);
    oob_o  = (32'(x_i) >= 32'(MAP_W)) || (32'(y_i) >= 32'(MAP_H));
  end

endmodule

// File: rtl/barrier_ctrl.sv
// Command-driven sequencer for the single-port barrier SRAM: probes, single
// writes and whole-map fills, with bounds checking and collision responses.
module barrier_ctrl
  import barrier_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    X_WIDTH    = 8,
  parameter int                    Y_WIDTH    = 8,
  parameter int                    MAP_W      = DEF_MAP_W,
  parameter int                    MAP_H      = DEF_MAP_H,
  parameter logic [DATA_WIDTH-1:0] BG_VAL     = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [X_WIDTH-1:0]    cmd_x,
  input  logic [Y_WIDTH-1:0]    cmd_y,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  // One extra counter bit so a map filling the whole address space never wraps.
  localparam int               CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAP_W * MAP_H - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    oob_q, oob_d;
  logic                    busy_q, busy_d;
  logic                    en_q, en_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic                    cmd_oob;
  logic                    accept;

  barrier_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .X_WIDTH   (X_WIDTH),
    .Y_WIDTH   (Y_WIDTH),
    .MAP_W     (MAP_W),
    .MAP_H     (MAP_H)
  ) u_addr (
    .x_i   (cmd_x),
    .y_i   (cmd_y),
    .addr_o(cmd_addr),
    .oob_o (cmd_oob)
  );

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      oob_q       <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oob_q       <= oob_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op_e'(cmd_op))
            OP_PROBE: state_d = RD;
            OP_FILL:  state_d = FILL;
            OP_WRITE: state_d = WR;
            OP_RSVD:  state_d = WR;
          endcase
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = IDLE;
      WR:      state_d = IDLE;
      FILL:    if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d       = cnt_q;
    oob_d       = oob_q;
    en_d        = en_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_data_d  = '0;
    busy_d      = (state_d != IDLE);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          oob_d   = cmd_oob;
          addr_d  = cmd_addr;
          wdata_d = cmd_data;
          en_d    = 1'b0;
          we_d    = 1'b0;
          unique case (op_e'(cmd_op))
            OP_PROBE: en_d = !cmd_oob;
            OP_WRITE: begin
              en_d = !cmd_oob;
              we_d = !cmd_oob;
            end
            OP_FILL: begin
              cnt_d  = '0;
              addr_d = '0;
              oob_d  = 1'b0;
              en_d   = 1'b1;
              we_d   = 1'b1;
            end
            OP_RSVD: oob_d = 1'b0;
          endcase
        end
      end
      RD: en_d = 1'b0;
      CAP: begin
        // Out-of-range probes never touched the SRAM, so rdata is stale here.
        rsp_valid_d = 1'b1;
        rsp_hit_d   = oob_q || (sram_rdata != BG_VAL);
        rsp_data_d  = oob_q ? '0 : sram_rdata;
      end
      WR: begin
        en_d        = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = oob_q;
      end
      FILL: begin
        if (cnt_q == LAST) begin
          en_d        = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = ADDR_WIDTH'(cnt_q + 1'b1);
        end
      end
      default: ;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;
  assign sram_en    = en_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_barrier_ctrl.sv
// Directed bench for barrier_ctrl: three instances (4x4 full-address-space map,
// 256x8 map, 200-wide map), each with a behavioural 1-cycle registered SRAM.
module tb_barrier_ctrl;
  import barrier_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid [3];
  logic [1:0] cmd_op    [3];
  logic [7:0] cmd_x     [3];
  logic [7:0] cmd_y     [3];
  logic [7:0] cmd_data  [3];

  logic        ready0, rv0, hit0, busy0, en0, we0;
  logic        ready1, rv1, hit1, busy1, en1, we1;
  logic        ready2, rv2, hit2, busy2, en2, we2;
  logic [7:0]  rd0, wd0, srd0, rd1, wd1, srd1, rd2, wd2, srd2;
  logic [3:0]  a0;
  logic [15:0] a1, a2;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [2048];
  logic [7:0] mem2 [65536];

  typedef struct packed {
    logic        ready, rv, hit, busy, en, we;
    logic [15:0] addr;
    logic [7:0]  rdata, wdata;
  } mon_t;
  mon_t mon [3];

  int n_checks = 0;
  int n_err    = 0;

  barrier_ctrl #(.ADDR_WIDTH(4), .MAP_W(4), .MAP_H(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[0]), .cmd_ready(ready0),
    .cmd_op(cmd_op[0]), .cmd_x(cmd_x[0]), .cmd_y(cmd_y[0]), .cmd_data(cmd_data[0]),
    .rsp_valid(rv0), .rsp_hit(hit0), .rsp_data(rd0), .busy(busy0),
    .sram_en(en0), .sram_we(we0), .sram_addr(a0), .sram_wdata(wd0), .sram_rdata(srd0)
  );

  barrier_ctrl #(.MAP_W(256), .MAP_H(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[1]), .cmd_ready(ready1),
    .cmd_op(cmd_op[1]), .cmd_x(cmd_x[1]), .cmd_y(cmd_y[1]), .cmd_data(cmd_data[1]),
    .rsp_valid(rv1), .rsp_hit(hit1), .rsp_data(rd1), .busy(busy1),
    .sram_en(en1), .sram_we(we1), .sram_addr(a1), .sram_wdata(wd1), .sram_rdata(srd1)
  );

  barrier_ctrl #(.MAP_W(200), .MAP_H(256)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[2]), .cmd_ready(ready2),
    .cmd_op(cmd_op[2]), .cmd_x(cmd_x[2]), .cmd_y(cmd_y[2]), .cmd_data(cmd_data[2]),
    .rsp_valid(rv2), .rsp_hit(hit2), .rsp_data(rd2), .busy(busy2),
    .sram_en(en2), .sram_we(we2), .sram_addr(a2), .sram_wdata(wd2), .sram_rdata(srd2)
  );

  always @(posedge clk) if (en0) begin
    if (we0) mem0[a0] <= wd0;
    else     srd0 <= mem0[a0];
  end
  always @(posedge clk) if (en1) begin
    if (we1) mem1[a1[10:0]] <= wd1;
    else     srd1 <= mem1[a1[10:0]];
  end
  always @(posedge clk) if (en2) begin
    if (we2) mem2[a2] <= wd2;
    else     srd2 <= mem2[a2];
  end

  always_comb begin
    mon[0] = {ready0, rv0, hit0, busy0, en0, we0, {12'h000, a0}, rd0, wd0};
    mon[1] = {ready1, rv1, hit1, busy1, en1, we1, a1, rd1, wd1};
    mon[2] = {ready2, rv2, hit2, busy2, en2, we2, a2, rd2, wd2};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command; returns at the negedge right after the accept edge.
  task automatic send(input int u, input logic [1:0] op, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] d);
    @(negedge clk);
    check($sformatf("ready_before_cmd_u%0d", u), 32'(mon[u].ready), 32'd1);
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    cmd_x[u]     = x;
    cmd_y[u]     = y;
    cmd_data[u]  = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[u] = 1'b0;
  endtask

  task automatic probe_chk(input int u, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] exp_d, input logic exp_hit, input string tag);
    send(u, OP_PROBE, x, y, 8'h00);
    @(negedge clk);
    check({tag, "_t1_rv"}, 32'(mon[u].rv), 32'd0);
    @(negedge clk);
    check({tag, "_rv"}, 32'(mon[u].rv), 32'd1);
    check({tag, "_data"}, 32'(mon[u].rdata), 32'(exp_d));
    check({tag, "_hit"}, 32'(mon[u].hit), 32'(exp_hit));
  endtask

  initial begin
    int wr_cnt;
    int en_seen;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = 2'b00;
      cmd_x[i]     = 8'h00;
      cmd_y[i]     = 8'h00;
      cmd_data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_ctrl_u0", {mon[0].ready, mon[0].rv, mon[0].busy, mon[0].en, mon[0].we}, 32'b10000);
    check("reset_addr_u1", 32'(mon[1].addr), 32'h0);
    reset_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_u1", {mon[1].ready, mon[1].busy, mon[1].rv, mon[1].en, mon[1].we}, 32'b10000);
    end

    // Clear the 256x8 map: 2048 consecutive write cycles, then the ack.
    send(1, OP_FILL, 8'hFF, 8'hFF, 8'h00);
    wr_cnt = 0;
    for (int k = 0; k < 2048; k++) begin
      if (mon[1].en && mon[1].we && mon[1].addr == 16'(k)) wr_cnt++;
      @(negedge clk);
    end
    check("fill1_writes", 32'(wr_cnt), 32'd2048);
    check("fill1_ack", {mon[1].rv, mon[1].hit, mon[1].en, mon[1].we}, 32'b1000);

    // Single write of (5,3).
    send(1, OP_WRITE, 8'd5, 8'd3, 8'h0F);
    check("wr_en_we", {mon[1].en, mon[1].we, mon[1].rv}, 32'b110);
    check("wr_addr", 32'(mon[1].addr), 32'h0305);
    check("wr_wdata", 32'(mon[1].wdata), 32'h0F);
    @(negedge clk);
    check("wr_ack", {mon[1].en, mon[1].we, mon[1].rv, mon[1].hit, mon[1].ready}, 32'b00101);
    @(negedge clk);
    check("wr_pulse_one", 32'(mon[1].rv), 32'd0);

    probe_chk(1, 8'd5, 8'd3, 8'h0F, 1'b1, "probe_5_3");
    probe_chk(1, 8'd6, 8'd3, 8'h00, 1'b0, "probe_6_3");

    // 200-wide map: x=200 is out of bounds, x=199 is the last column.
    send(2, OP_PROBE, 8'd200, 8'd0, 8'h00);
    en_seen = int'(mon[2].en);
    @(negedge clk);
    en_seen += int'(mon[2].en);
    check("oobp_t1_rv", 32'(mon[2].rv), 32'd0);
    @(negedge clk);
    en_seen += int'(mon[2].en);
    check("oobp_no_en", 32'(en_seen), 32'd0);
    check("oobp_rsp", {mon[2].rv, mon[2].hit}, 32'b11);
    check("oobp_data", 32'(mon[2].rdata), 32'h0);

    send(2, OP_WRITE, 8'd250, 8'd10, 8'h77);
    check("oobw_no_wr", {mon[2].en, mon[2].we}, 32'b00);
    @(negedge clk);
    check("oobw_ack", {mon[2].rv, mon[2].hit, mon[2].en, mon[2].we}, 32'b1100);

    send(2, OP_PROBE, 8'd199, 8'd0, 8'h00);
    check("edge_x199_en", {mon[2].en, mon[2].we}, 32'b10);
    check("edge_x199_addr", 32'(mon[2].addr), 32'd199);
    repeat (2) @(negedge clk);

    send(2, OP_RSVD, 8'd1, 8'd1, 8'h55);
    check("rsvd_no_en", {mon[2].en, mon[2].we}, 32'b00);
    @(negedge clk);
    check("rsvd_ack", {mon[2].rv, mon[2].hit}, 32'b10);

    // 4x4 map spanning the full 4-bit address space.
    send(0, OP_FILL, 8'd0, 8'd0, 8'hAA);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fill0_cyc%0d", k),
            {mon[0].ready, mon[0].busy, mon[0].en, mon[0].we, mon[0].addr},
            {12'h0, 4'b0111, 16'(k)});
      @(negedge clk);
    end
    check("fill0_ack", {mon[0].rv, mon[0].hit, mon[0].en, mon[0].we}, 32'b1000);
    @(negedge clk);
    check("fill0_idle", {mon[0].rv, mon[0].busy, mon[0].ready}, 32'b001);

    probe_chk(0, 8'd0, 8'd0, 8'hAA, 1'b1, "probe0_0_0");
    probe_chk(0, 8'd3, 8'd3, 8'hAA, 1'b1, "probe0_3_3");
    probe_chk(0, 8'd4, 8'd0, 8'h00, 1'b1, "probe0_oob_x4");

    // Reset lands while the fill is presenting address 7.
    send(0, OP_FILL, 8'd0, 8'd0, 8'h3C);
    repeat (7) @(negedge clk);
    check("abort_at_addr", 32'(mon[0].addr), 32'd7);
    reset_n = 1'b0;
    #1;
    check("abort_drop", {mon[0].en, mon[0].we, mon[0].busy, mon[0].rv, mon[0].ready}, 32'b00001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(mon[0].rv), 32'd0);
    end
    reset_n = 1'b1;

    probe_chk(0, 8'd2, 8'd2, 8'hAA, 1'b1, "after_abort_addr10");
    probe_chk(0, 8'd2, 8'd1, 8'h3C, 1'b1, "after_abort_addr6");
    probe_chk(0, 8'd3, 8'd1, 8'hAA, 1'b1, "after_abort_addr7");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
